fb_arbiter: RTL

Shares one single-port framebuffer RAM between two requesters: the VGA scan-out reader, which is real-time and always has priority, and a pixel writer (UART/pattern loader), which is queued. The writer uses a valid/ready handshake into an internal write FIFO that drains into RAM cycles the reader leaves idle. The block sits between the VGA timing/pixel pipeline and the framebuffer RAM and drives the RAM's address, data and write-enable inputs directly.

---
 rtl/fb_arbiter_if.sv | 40 ++++
 rtl/fb_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus: reader, writer and RAM-side signals.
// slave = arbiter side, master = client/environment side.
interface fb_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_AW    = 2
);
  logic                  i_rd_req;
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic                  o_rd_valid;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  i_wr_valid;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [DATA_WIDTH-1:0] i_wr_data;
  logic                  o_wr_ready;
  logic [FIFO_AW:0]      o_wr_level;
  logic                  o_wr_idle;
  logic [ADDR_WIDTH-1:0] o_ram_addr;
  logic [DATA_WIDTH-1:0] o_ram_data;
  logic                  o_ram_write_en;
  logic [DATA_WIDTH-1:0] i_ram_data;

  modport slave (
    input  i_rd_req, i_rd_addr,
    output o_rd_valid, o_rd_data,
    input  i_wr_valid, i_wr_addr, i_wr_data,
    output o_wr_ready, o_wr_level, o_wr_idle,
    output o_ram_addr, o_ram_data, o_ram_write_en,
    input  i_ram_data
  );

  modport master (
    output i_rd_req, i_rd_addr,
    input  o_rd_valid, o_rd_data,
    output i_wr_valid, i_wr_addr, i_wr_data,
    input  o_wr_ready, o_wr_level, o_wr_idle,
    input  o_ram_addr, o_ram_data, o_ram_write_en,
    output i_ram_data
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: VGA reader has priority, writer queued.
// Define FB_ARBITER_STALL_CNT_EN to build the writer stall counter.
module fb_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  fb_arbiter_if.slave bus,
  output logic [15:0] o_stall_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_READ,
    GNT_WRITE
  } grant_e;

  grant_e grant;

  logic [FIFO_AW:0]      wr_ptr;
  logic [FIFO_AW:0]      rd_ptr;
  logic [FIFO_AW:0]      level;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  rd_valid_q;
  logic [ADDR_WIDTH-1:0] fifo_addr [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign level = wr_ptr - rd_ptr;
  assign full  = level[FIFO_AW];
  assign empty = (level == '0);

  // No bypass when full: ready comes only from registered occupancy
  assign push = bus.i_wr_valid & ~full;

  assign head_addr = fifo_addr[rd_ptr[FIFO_AW-1:0]];
  assign head_data = fifo_data[rd_ptr[FIFO_AW-1:0]];

  always_comb begin
    grant = GNT_IDLE;
    unique case (1'b1)
      bus.i_rd_req:           grant = GNT_READ;
      !bus.i_rd_req && !empty: grant = GNT_WRITE;
      default:                grant = GNT_IDLE;
    endcase
  end

  assign pop = (grant == GNT_WRITE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      rd_valid_q <= (grant == GNT_READ);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wr_ptr[FIFO_AW-1:0]] <= bus.i_wr_addr;
      fifo_data[wr_ptr[FIFO_AW-1:0]] <= bus.i_wr_data;
    end
  end

  assign bus.o_ram_write_en = pop;
  assign bus.o_ram_addr     = pop ? head_addr : bus.i_rd_addr;
  assign bus.o_ram_data     = head_data;
  assign bus.o_rd_valid     = rd_valid_q;
  assign bus.o_rd_data      = bus.i_ram_data;
  assign bus.o_wr_ready     = ~full;
  assign bus.o_wr_level     = level;
  assign bus.o_wr_idle      = empty & ~pop;

`ifdef FB_ARBITER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
    end else if (bus.i_rd_req && !empty
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
